// File: rtl/ac_pkg.sv
// Shared definitions for the hysteresis AC controller.
// Holds the state encodings, actuator and mode codes, and the helper used to
// size the dwell counter.
package ac_pkg;

  typedef enum logic [2:0] {
    ST_OFF      = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DECREASE = 3'd2,
    ST_INCREASE = 3'd3,
    ST_GUARD    = 3'd4
  } state_t;

  localparam logic [1:0] ACT_NONE = 2'b00;
  localparam logic [1:0] ACT_HEAT = 2'b01;
  localparam logic [1:0] ACT_COOL = 2'b10;

  localparam logic [1:0] MODE_AUTO      = 2'b00;
  localparam logic [1:0] MODE_HEAT_ONLY = 2'b01;
  localparam logic [1:0] MODE_COOL_ONLY = 2'b10;

  // Saturation point of the dwell counter: it must reach both the last
  // run-time cycle and the last guard cycle.
  function automatic int dwell_max(input int min_run, input int guard);
    return (min_run > guard) ? min_run : guard;
  endfunction

endpackage

// File: rtl/ac_temp_compare.sv
// Temperature comparator with hysteresis and mode masking. Purely combinational.
// Ports:
//   cur_temp, set_temp  in  TEMP_W  measured / target temperature (unsigned)
//   mode                in  2       AUTO / HEAT_ONLY / COOL_ONLY (11 = AUTO)
//   too_hot, too_cold   out 1       outside the hysteresis band (mode-masked)
//   reached_cool        out 1       cur_temp <= set_temp
//   reached_heat        out 1       cur_temp >= set_temp
module ac_temp_compare
  import ac_pkg::*;
#(
  parameter int TEMP_W = 8,
  parameter int HYST   = 2
) (
  input  logic [TEMP_W-1:0] cur_temp,
  input  logic [TEMP_W-1:0] set_temp,
  input  logic [1:0]        mode,
  output logic              too_hot,
  output logic              too_cold,
  output logic              reached_cool,
  output logic              reached_heat
);

  // One extra bit so that set_temp + HYST and cur_temp + HYST never wrap.
  localparam logic [TEMP_W:0] HYST_X = (TEMP_W+1)'(HYST);

  logic [TEMP_W:0] cur_x;
  logic [TEMP_W:0] set_x;

  assign cur_x = {1'b0, cur_temp};
  assign set_x = {1'b0, set_temp};

  assign too_hot      = (cur_x > set_x + HYST_X) && (mode != MODE_HEAT_ONLY);
  assign too_cold     = (cur_x + HYST_X < set_x) && (mode != MODE_COOL_ONLY);
  assign reached_cool = (cur_x <= set_x);
  assign reached_heat = (cur_x >= set_x);

endmodule

// File: rtl/ac_controller_hyst.sv
// AC controller with hysteresis, minimum run time and compressor guard.
//
// state    | meaning
// ---------+----------------------------------------------------------
// OFF      | unit disabled (power=0 or reset); no action
// IDLE     | temperature within band; no action
// DECREASE | cooling; held at least MIN_RUN cycles
// INCREASE | heating; held at least MIN_RUN cycles
// GUARD    | compressor rest for exactly GUARD cycles on a reversal
//
// Ports:
//   clk            in   1       system clock, rising edge
//   reset          in   1       synchronous, active-high
//   power          in   1       1 = unit enabled
//   mode           in   2       00 AUTO, 01 HEAT_ONLY, 10 COOL_ONLY, 11 AUTO
//   cur_temp       in   TEMP_W  measured temperature
//   set_temp       in   TEMP_W  target temperature
//   action         out  2       00 none, 01 heat, 10 cool
//   state_display  out  3       current state encoding
module ac_controller_hyst
  import ac_pkg::*;
#(
  parameter int TEMP_W  = 8,
  parameter int HYST    = 2,
  parameter int MIN_RUN = 4,
  parameter int GUARD   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              power,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] cur_temp,
  input  logic [TEMP_W-1:0] set_temp,
  output logic [1:0]        action,
  output logic [2:0]        state_display
);

  localparam int DWELL_MAX = dwell_max(MIN_RUN, GUARD);
  localparam int CNT_W     = $clog2(DWELL_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DWELL_MAX);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(MIN_RUN - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] dwell_cnt;
  logic             dwell_ok;

  logic too_hot;
  logic too_cold;
  logic reached_cool;
  logic reached_heat;

  ac_temp_compare #(
    .TEMP_W (TEMP_W),
    .HYST   (HYST)
  ) u_cmp (
    .cur_temp     (cur_temp),
    .set_temp     (set_temp),
    .mode         (mode),
    .too_hot      (too_hot),
    .too_cold     (too_cold),
    .reached_cool (reached_cool),
    .reached_heat (reached_heat)
  );

  // Counter value MIN_RUN-1 means the current cycle is the MIN_RUN-th in state.
  assign dwell_ok = (dwell_cnt >= RUN_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_OFF;
      dwell_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        dwell_cnt <= '0;
      end else if (dwell_cnt != CNT_MAX) begin
        dwell_cnt <= dwell_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    if (!power) begin
      state_nxt = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          if (too_hot)       state_nxt = ST_DECREASE;
          else if (too_cold) state_nxt = ST_INCREASE;
          else               state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (too_hot)       state_nxt = ST_DECREASE;
          else if (too_cold) state_nxt = ST_INCREASE;
        end
        ST_DECREASE: begin
          if (dwell_ok) begin
            if (too_cold)          state_nxt = ST_GUARD;
            else if (reached_cool) state_nxt = ST_IDLE;
          end
        end
        ST_INCREASE: begin
          if (dwell_ok) begin
            if (too_hot)           state_nxt = ST_GUARD;
            else if (reached_heat) state_nxt = ST_IDLE;
          end
        end
        ST_GUARD: begin
          if (dwell_cnt == GUARD_LAST) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_OFF;
      endcase
    end
  end

  always_comb begin
    action = ACT_NONE;
    case (state)
      ST_DECREASE: action = ACT_COOL;
      ST_INCREASE: action = ACT_HEAT;
      default:     action = ACT_NONE;
    endcase
  end

  assign state_display = state;

endmodule

// File: tb/tb_ac_controller_hyst.sv
module tb_ac_controller_hyst;

  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_IDL = 3'd1;
  localparam logic [2:0] S_DEC = 3'd2;
  localparam logic [2:0] S_INC = 3'd3;
  localparam logic [2:0] S_GRD = 3'd4;

  logic       clk;
  logic       reset;
  logic       power;
  logic [1:0] mode;
  logic [7:0] cur_temp;
  logic [7:0] set_temp;
  logic [1:0] action;
  logic [2:0] state_display;

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [1:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ac_controller_hyst #(
    .TEMP_W  (8),
    .HYST    (2),
    .MIN_RUN (4),
    .GUARD   (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .power         (power),
    .mode          (mode),
    .cur_temp      (cur_temp),
    .set_temp      (set_temp),
    .action        (action),
    .state_display (state_display)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] act_of(input logic [2:0] st);
    if (st == S_DEC) return 2'b10;
    if (st == S_INC) return 2'b01;
    return 2'b00;
  endfunction

  // One call = one rising edge; the expected state after that edge is queued.
  task automatic drive(input string name, input logic rst, input logic pwr,
                       input logic [1:0] md, input logic [7:0] cur,
                       input logic [7:0] set, input logic [2:0] exp_st);
    exp_t e;
    @(negedge clk);
    reset    = rst;
    power    = pwr;
    mode     = md;
    cur_temp = cur;
    set_temp = set;
    e.name = name;
    e.st   = exp_st;
    e.act  = act_of(exp_st);
    exp_q.push_back(e);
  endtask

  // Monitor: compares the DUT output after each edge against the queue head.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (state_display !== e.st || action !== e.act) begin
        failures++;
        $display("FAIL %s: state=%0d action=%b, required state=%0d action=%b",
                 e.name, state_display, action, e.st, e.act);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    power    = 1'b0;
    mode     = 2'b00;
    cur_temp = 8'd20;
    set_temp = 8'd20;

    // 1. reset, then power-up in band
    drive("rst0", 1, 0, 0, 20, 20, S_OFF);
    drive("rst1", 1, 0, 0, 20, 20, S_OFF);
    drive("pwr_up_idle", 0, 1, 0, 20, 20, S_IDL);

    // 2. cooling with minimum run, then back to IDLE
    drive("cool_start", 0, 1, 0, 25, 20, S_DEC);
    drive("cool_min2",  0, 1, 0, 19, 20, S_DEC);
    drive("cool_min3",  0, 1, 0, 19, 20, S_DEC);
    drive("cool_min4",  0, 1, 0, 19, 20, S_DEC);
    drive("cool_done",  0, 1, 0, 19, 20, S_IDL);
    drive("idle_hold",  0, 1, 0, 19, 20, S_IDL);

    // 3. cool -> heat reversal through GUARD
    drive("rev_dec1",  0, 1, 0, 25, 20, S_DEC);
    drive("rev_dec2",  0, 1, 0, 15, 20, S_DEC);
    drive("rev_dec3",  0, 1, 0, 15, 20, S_DEC);
    drive("rev_dec4",  0, 1, 0, 15, 20, S_DEC);
    drive("rev_grd1",  0, 1, 0, 15, 20, S_GRD);
    drive("rev_grd2",  0, 1, 0, 15, 20, S_GRD);
    drive("rev_grd3",  0, 1, 0, 15, 20, S_GRD);
    drive("rev_idle",  0, 1, 0, 15, 20, S_IDL);
    drive("rev_inc1",  0, 1, 0, 15, 20, S_INC);

    // 4. power drop mid-INCREASE, fresh dwell after power-up
    drive("inc2",        0, 1, 0, 15, 20, S_INC);
    drive("pwr_drop",    0, 0, 0, 15, 20, S_OFF);
    drive("pwr_inc1",    0, 1, 0, 10, 20, S_INC);
    drive("pwr_inc2",    0, 1, 0, 20, 20, S_INC);
    drive("pwr_inc3",    0, 1, 0, 20, 20, S_INC);
    drive("pwr_inc4",    0, 1, 0, 20, 20, S_INC);
    drive("pwr_inc_end", 0, 1, 0, 20, 20, S_IDL);
    // same with reset
    drive("r_inc1",      0, 1, 0, 10, 20, S_INC);
    drive("r_inc2",      0, 1, 0, 10, 20, S_INC);
    drive("r_reset",     1, 1, 0, 10, 20, S_OFF);
    drive("r_re_inc1",   0, 1, 0, 10, 20, S_INC);
    drive("r_re_inc2",   0, 1, 0, 20, 20, S_INC);
    drive("r_re_inc3",   0, 1, 0, 20, 20, S_INC);
    drive("r_re_inc4",   0, 1, 0, 20, 20, S_INC);
    drive("r_re_end",    0, 1, 0, 20, 20, S_IDL);
    // power drop mid-GUARD overrides the guard interval
    drive("g_dec1",      0, 1, 0, 25, 20, S_DEC);
    drive("g_dec2",      0, 1, 0, 15, 20, S_DEC);
    drive("g_dec3",      0, 1, 0, 15, 20, S_DEC);
    drive("g_dec4",      0, 1, 0, 15, 20, S_DEC);
    drive("g_grd1",      0, 1, 0, 15, 20, S_GRD);
    drive("g_pwr_drop",  0, 0, 0, 15, 20, S_OFF);
    drive("g_pwr_up",    0, 1, 0, 20, 20, S_IDL);

    // 5. boundaries
    drive("b_255_254",   0, 1, 0, 255, 254, S_IDL);
    drive("b_255_0",     0, 1, 0, 255,   0, S_DEC);
    drive("b_off1",      0, 0, 0, 255,   0, S_OFF);
    drive("b_0_255",     0, 1, 0,   0, 255, S_INC);
    drive("b_off2",      0, 0, 0,   0, 255, S_OFF);
    drive("b_22_20",     0, 1, 0,  22,  20, S_IDL);
    drive("b_23_20",     0, 1, 0,  23,  20, S_DEC);
    drive("b_off3",      0, 0, 0,  23,  20, S_OFF);
    drive("b_18_20",     0, 1, 0,  18,  20, S_IDL);
    drive("b_17_20",     0, 1, 0,  17,  20, S_INC);
    drive("b_off4",      0, 0, 0,  17,  20, S_OFF);

    // 6. mode masking
    drive("heat_only_hot",  0, 1, 1, 30, 20, S_IDL);
    drive("heat_only_hold", 0, 1, 1, 30, 20, S_IDL);
    drive("auto_hot",       0, 1, 0, 30, 20, S_DEC);
    drive("m_off1",         0, 0, 0, 30, 20, S_OFF);
    drive("cool_only_cold", 0, 1, 2, 10, 20, S_IDL);
    drive("auto_cold",      0, 1, 0, 10, 20, S_INC);
    drive("m_off2",         0, 0, 0, 10, 20, S_OFF);
    drive("mode11_hot",     0, 1, 3, 30, 20, S_DEC);
    drive("mode11_cool",    0, 1, 3, 10, 20, S_DEC);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ac_controller_hyst.md
# ac_controller_hyst

Parametrised successor to the four-state AC controller. It compares a measured temperature against a setpoint internally, using a configurable hysteresis band, instead of taking a pre-computed 2-bit comparison. It enforces a minimum run time in the heating and cooling states and a compressor guard interval on heat/cool reversal, and supports heat-only and cool-only modes. It sits between the temperature sensor register and the actuator driver, with a single clock domain.

## Interface
- `TEMP_W`, default 8: width of the temperature and setpoint values (unsigned).
- `HYST`, default 2: hysteresis margin in temperature LSBs. Must be less than 2^TEMP_W.
- `MIN_RUN`, default 4: minimum number of cycles held in DECREASE/INCREASE. Must be at least 1.
- `GUARD`, default 3: exact number of cycles spent in GUARD on a direction reversal. Must be at least 1.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `power`  in  1  1 = unit enabled.
- `mode`  in  2  00 AUTO, 01 HEAT_ONLY, 10 COOL_ONLY, 11 treated as AUTO.
- `cur_temp`  in  TEMP_W  measured temperature.
- `set_temp`  in  TEMP_W  target temperature.
- `action`  out  2  00 none, 01 heat (increase), 10 cool (decrease); 11 is never driven.
- `state_display`  out  3  current state: OFF=0, IDLE=1, DECREASE=2, INCREASE=3, GUARD=4.

## Operation
**Comparison**
- All comparisons use TEMP_W+1-bit zero-extended arithmetic, so `set_temp+HYST` never wraps.
- too_hot = cur_temp > set_temp + HYST.
- too_cold = cur_temp + HYST < set_temp.
- reached_cool = cur_temp <= set_temp.
- reached_heat = cur_temp >= set_temp.

**Mode masking**
- HEAT_ONLY forces too_hot = 0.
- COOL_ONLY forces too_cold = 0.

**Dwell counter**
- Cleared on every state change and on reset.
- Otherwise increments, saturating at max(MIN_RUN, GUARD).
- "dwell_ok" means the counter is at least MIN_RUN-1; this counts the current cycle as the MIN_RUN-th cycle in the state.

**Transitions (highest priority first)**
- reset → OFF.
- power=0 → OFF from any state. This overrides the dwell and guard rules.
- OFF: too_hot → DECREASE; too_cold → INCREASE; otherwise → IDLE.
- IDLE: too_hot → DECREASE; too_cold → INCREASE; otherwise stay.
- DECREASE: if not dwell_ok, stay. Else too_cold → GUARD; else reached_cool → IDLE; else stay.
- INCREASE: if not dwell_ok, stay. Else too_hot → GUARD; else reached_heat → IDLE; else stay.
- GUARD: stay until the counter equals GUARD-1, then → IDLE. Inputs are ignored in GUARD except power.

**Outputs**
- Moore outputs, decoded from the registered state only.
- action is 10 in DECREASE, 01 in INCREASE, 00 in all other states.

## Timing
- Reset values: state OFF, `state_display`=0, `action`=00, dwell counter 0.
- Inputs are sampled on each rising edge. The new state and outputs are visible immediately after that edge, giving a 1-cycle latency from input change to output.
- A heat/cool reversal takes at least MIN_RUN cycles in the old state, then GUARD cycles in GUARD, then 1 cycle in IDLE, before the opposite action starts.
- Reset or power=0 asserted mid-run (including mid-GUARD) reaches OFF on the next edge and clears the counter. A later power-up starts a fresh dwell.
- Changing `mode` or `set_temp` mid-run takes effect on the next evaluation and is still subject to dwell_ok.

## Structure
- Package `ac_pkg` holds:
  - state encodings (3-bit);
  - action codes;
  - mode codes;
  - a function returning max(MIN_RUN, GUARD), used to size the counter via $clog2(max+1).
- Sub-module `ac_temp_compare`: purely combinational; takes the temperatures, HYST and mode, and produces too_hot, too_cold, reached_cool and reached_heat.
- The top level holds the state register, dwell counter and output decode.

## Test plan
All scenarios use TEMP_W=8, HYST=2, MIN_RUN=4, GUARD=3.
1. Reset for 2 cycles with power=0 → state 0, action 00. Then power=1, cur=20, set=20 → next edge state 1, action 00.
2. From IDLE, cur=25, set=20 → state 2, action 10. Then cur=19 on the next cycle → stays in state 2 for 4 cycles total, then state 1.
3. In DECREASE, set cur=15 after 1 cycle (set=20) → state 2 for 4 cycles, GUARD (state 4, action 00) for exactly 3 cycles, state 1 for 1 cycle, then state 3 with action 01.
4. Drop power=0 in the 2nd cycle of INCREASE → state 0 on the next edge. Power=1 with cur=10, set=20 → INCREASE again with a full 4-cycle dwell. Repeat with reset instead of power → same result.
5. Boundaries:
   - cur=255, set=254 → IDLE (no wrap).
   - cur=255, set=0 → DECREASE.
   - cur=0, set=255 → INCREASE.
   - cur=22, set=20 → IDLE; cur=23, set=20 → DECREASE.
6. mode=HEAT_ONLY, cur=30, set=20 → IDLE with action 00. Then mode=AUTO → DECREASE on the next edge.
